// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types for the D-cache port arbiter.
//   word_addr_t / word_t / mask_t : memory word address, data word and byte enables
//   arb_state_t                   : aux-port sequencing states (IDLE, ISSUE, WAIT)
//   owner_t                       : which port owned the cache request last cycle
//   countWidth()                  : register width able to hold 0..states-1, never below 1
package dcache_port_arbiter_pkg;

  typedef logic [29:0] word_addr_t;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  mask_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
  typedef enum logic [1:0] {OWNER_NONE, OWNER_C, OWNER_A} owner_t;

  function automatic int countWidth(input int states);
    return (states <= 2) ? 1 : $clog2(states);
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// Bundle of all handshake/bus signals around the D-cache port arbiter.
//   port C : cEn, cEnW, cAddr, cReqData, cMask  -> cRespData, cNack, cBackoff
//   port A : aValid, aWe, aAddr, aWData, aMask  -> aReady, aRspValid, aRspData, aRspErr
//   cache  : mEn, mEnW, mAddr, mReqData, mMask  <- mRespData, mNack
// Modport slave is the arbiter's view; master is the surrounding core/aux/cache view.
interface dcache_port_arbiter_if;
  import dcache_port_arbiter_pkg::*;

  logic       cEn;
  logic       cEnW;
  word_addr_t cAddr;
  word_t      cReqData;
  mask_t      cMask;
  word_t      cRespData;
  logic       cNack;
  logic       cBackoff;

  logic       aValid;
  logic       aReady;
  logic       aWe;
  word_addr_t aAddr;
  word_t      aWData;
  mask_t      aMask;
  logic       aRspValid;
  word_t      aRspData;
  logic       aRspErr;

  logic       mEn;
  logic       mEnW;
  word_addr_t mAddr;
  word_t      mReqData;
  mask_t      mMask;
  word_t      mRespData;
  logic       mNack;

  modport slave (
    input  cEn, cEnW, cAddr, cReqData, cMask,
    output cRespData, cNack, cBackoff,
    input  aValid, aWe, aAddr, aWData, aMask,
    output aReady, aRspValid, aRspData, aRspErr,
    output mEn, mEnW, mAddr, mReqData, mMask,
    input  mRespData, mNack
  );

  modport master (
    output cEn, cEnW, cAddr, cReqData, cMask,
    input  cRespData, cNack, cBackoff,
    output aValid, aWe, aAddr, aWData, aMask,
    input  aReady, aRspValid, aRspData, aRspErr,
    input  mEn, mEnW, mAddr, mReqData, mMask,
    output mRespData, mNack
  );

endinterface

// File: rtl/dcache_port_arbiter.sv
// Shares the single-ported L1 D-cache core port between the memory stage (port C,
// fixed priority, zero latency, never stalled) and an aux requester (port A, valid/ready).
// A's request is captured, issued whenever C is idle, replayed on cache nAck up to
// MAX_RETRY times, then completed with a one-cycle aRspValid pulse (aRspErr on final nAck).
// Ports:
//   clk  : clock, all state on posedge
//   rst  : synchronous active-low reset
//   bus  : dcache_port_arbiter_if.slave (port C, port A and cache-side signals)
// Parameters: MAX_RETRY (replays before error), STARVE_LIMIT (blocked cycles before cBackoff).
// Optional feature: define DCACHE_ARB_STARVE_GUARD_EN to enable the cBackoff starvation guard;
// without it cBackoff is tied low and A may starve under continuous C traffic.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int MAX_RETRY    = 3,
  parameter int STARVE_LIMIT = 8
) (
  input logic                  clk,
  input logic                  rst,
  dcache_port_arbiter_if.slave bus
);

  localparam int RETRY_W = countWidth(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  arb_state_t         state;
  owner_t             lastOwner;
  logic [RETRY_W-1:0] retryCnt;
  logic               aReqWe;
  word_addr_t         aReqAddr;
  word_t              aReqWData;
  mask_t              aReqMask;

  logic aIssue;
  logic aRetry;
  logic aDone;

  // A only reaches the cache on cycles C leaves free; a WAIT cycle either replays
  // (nAck with budget left) or completes the request.
  always_comb begin
    aIssue = rst && (state == ISSUE) && !bus.cEn;
    aRetry = (state == WAIT) && bus.mNack && (retryCnt < RETRY_MAX);
    aDone  = rst && (state == WAIT) && !aRetry;
  end

  // Cache request mux: C passes straight through and always wins, otherwise the
  // held A request is presented during an issue cycle.
  always_comb begin
    bus.mEn      = 1'b0;
    bus.mEnW     = 1'b0;
    bus.mAddr    = '0;
    bus.mReqData = '0;
    bus.mMask    = '0;
    if (rst && bus.cEn) begin
      bus.mEn      = 1'b1;
      bus.mEnW     = bus.cEnW;
      bus.mAddr    = bus.cAddr;
      bus.mReqData = bus.cReqData;
      bus.mMask    = bus.cMask;
    end else if (aIssue) begin
      bus.mEn      = 1'b1;
      bus.mEnW     = aReqWe;
      bus.mAddr    = aReqAddr;
      bus.mReqData = aReqWData;
      bus.mMask    = aReqMask;
    end
  end

  // Response routing: the response cycle belongs to whoever issued last cycle, so a
  // C nAck never leaks to A and an A nAck never shows up on cNack.
  always_comb begin
    bus.aReady    = rst && (state == IDLE);
    bus.aRspValid = aDone;
    bus.aRspData  = aReqWe ? '0 : bus.mRespData;
    bus.aRspErr   = aDone && bus.mNack;
    bus.cRespData = bus.mRespData;
    bus.cNack     = rst && bus.mNack && (lastOwner == OWNER_C);
  end

  // Port A sequencer plus response-ownership tracking. Reset drops any in-flight
  // A request and forgets the owner so a pending cache response is ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      lastOwner <= OWNER_NONE;
      retryCnt  <= '0;
      aReqWe    <= 1'b0;
      aReqAddr  <= '0;
      aReqWData <= '0;
      aReqMask  <= '0;
    end else begin
      if (bus.cEn) begin
        lastOwner <= OWNER_C;
      end else if (aIssue) begin
        lastOwner <= OWNER_A;
      end else begin
        lastOwner <= OWNER_NONE;
      end
      case (state)
        IDLE: begin
          if (bus.aValid) begin
            aReqWe    <= bus.aWe;
            aReqAddr  <= bus.aAddr;
            aReqWData <= bus.aWData;
            aReqMask  <= bus.aMask;
            retryCnt  <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (aIssue) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (aRetry) begin
            retryCnt <= retryCnt + 1'b1;
            state    <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = countWidth(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_LIMIT - 1);

  logic [STARVE_W-1:0] starveCnt;
  logic                aBlocked;

  // cBackoff fires on the STARVE_LIMIT-th consecutive blocked cycle; the counter then
  // restarts so a core that ignores the request sees another pulse a full window later.
  always_comb begin
    aBlocked     = (state == ISSUE) && bus.cEn;
    bus.cBackoff = rst && aBlocked && (starveCnt == STARVE_TOP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starveCnt <= '0;
    end else if (aBlocked) begin
      starveCnt <= (starveCnt == STARVE_TOP) ? '0 : starveCnt + 1'b1;
    end else begin
      starveCnt <= '0;
    end
  end
`else
  assign bus.cBackoff = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter. A small cache responder answers every
// request one cycle later with a fixed address-derived word and scripted nAcks; a
// request-level model predicts every output each cycle, and directed scenarios pin
// latencies, replay counts and data with literal values.
module tb_dcache_port_arbiter;
  import dcache_port_arbiter_pkg::*;

  localparam int MAX_RETRY    = 3;
  localparam int STARVE_LIMIT = 8;

  logic clk = 1'b0;
  logic rst;

  dcache_port_arbiter_if bus ();

  dcache_port_arbiter #(
    .MAX_RETRY   (MAX_RETRY),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Report one comparison; the only place the failure count is stepped.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t memWord(input word_addr_t addr);
    return {2'b00, addr} ^ 32'h5A5A_0000;
  endfunction

  // Cache stand-in: data for every request, nAck for C on demand, and a budget of
  // nAcks handed to A requests.
  int   aNacksGiven = 0;
  int   aNackLimit  = 0;
  logic nackC       = 1'b0;

  always @(posedge clk) begin
    bus.mRespData <= bus.mEn ? memWord(bus.mAddr) : 32'h0;
    bus.mNack     <= 1'b0;
    if (bus.mEn && bus.cEn) begin
      bus.mNack <= nackC;
    end else if (bus.mEn && (aNacksGiven < aNackLimit)) begin
      bus.mNack   <= 1'b1;
      aNacksGiven <= aNacksGiven + 1;
    end
  end

  // Request-level model: one pending A request that is either waiting for a free
  // cache slot or waiting for its response, plus who issued in the previous cycle.
  logic       mdlBusy    = 1'b0;
  logic       mdlAwait   = 1'b0;
  int         mdlNacks   = 0;
  int         mdlBlocked = 0;
  logic       mdlPrevC   = 1'b0;
  logic       mdlWe      = 1'b0;
  word_addr_t mdlAddr    = '0;
  word_t      mdlWData   = '0;
  mask_t      mdlMask    = '0;

  always @(negedge clk) begin
    logic issuingA, retry, expRsp, blocked, expBackoff;
    if (!rst) begin
      checkOutput("rstAReady", bus.aReady, 0);
      checkOutput("rstMEn", bus.mEn, 0);
      checkOutput("rstARspValid", bus.aRspValid, 0);
      checkOutput("rstCNack", bus.cNack, 0);
      checkOutput("rstCBackoff", bus.cBackoff, 0);
      mdlBusy    = 1'b0;
      mdlAwait   = 1'b0;
      mdlPrevC   = 1'b0;
      mdlBlocked = 0;
    end else begin
      issuingA = mdlBusy && !mdlAwait && !bus.cEn;
      blocked  = mdlBusy && !mdlAwait && bus.cEn;
      checkOutput("aReady", bus.aReady, !mdlBusy);
      checkOutput("mEn", bus.mEn, bus.cEn || issuingA);
      if (bus.cEn) begin
        checkOutput("mAddrC", bus.mAddr, bus.cAddr);
        checkOutput("mEnWC", bus.mEnW, bus.cEnW);
        checkOutput("mDataC", bus.mReqData, bus.cReqData);
        checkOutput("mMaskC", bus.mMask, bus.cMask);
      end else if (issuingA) begin
        checkOutput("mAddrA", bus.mAddr, mdlAddr);
        checkOutput("mEnWA", bus.mEnW, mdlWe);
        checkOutput("mDataA", bus.mReqData, mdlWData);
        checkOutput("mMaskA", bus.mMask, mdlMask);
      end
      retry  = mdlAwait && bus.mNack && (mdlNacks < MAX_RETRY);
      expRsp = mdlAwait && !retry;
      checkOutput("aRspValid", bus.aRspValid, expRsp);
      if (expRsp) begin
        checkOutput("aRspData", bus.aRspData, mdlWe ? 32'h0 : memWord(mdlAddr));
        checkOutput("aRspErr", bus.aRspErr, bus.mNack);
      end
      checkOutput("cNack", bus.cNack, bus.mNack && mdlPrevC);
      checkOutput("cRespData", bus.cRespData, bus.mRespData);
`ifdef DCACHE_ARB_STARVE_GUARD_EN
      expBackoff = blocked && (((mdlBlocked + 1) % STARVE_LIMIT) == 0);
`else
      expBackoff = 1'b0;
`endif
      checkOutput("cBackoff", bus.cBackoff, expBackoff);

      mdlBlocked = blocked ? mdlBlocked + 1 : 0;
      mdlPrevC   = bus.cEn;
      if (!mdlBusy) begin
        if (bus.aValid) begin
          mdlBusy  = 1'b1;
          mdlAwait = 1'b0;
          mdlNacks = 0;
          mdlWe    = bus.aWe;
          mdlAddr  = bus.aAddr;
          mdlWData = bus.aWData;
          mdlMask  = bus.aMask;
        end
      end else if (issuingA) begin
        mdlAwait = 1'b1;
      end else if (mdlAwait) begin
        mdlAwait = 1'b0;
        if (retry) begin
          mdlNacks++;
        end else begin
          mdlBusy = 1'b0;
        end
      end
    end
  end

  // Offer one A request and hold it until the arbiter accepts it; returns just
  // after the accepting edge.
  task automatic applyStimulus(input logic we, input word_addr_t addr, input word_t wd,
                               input mask_t mk);
    logic acc;
    acc = 1'b0;
    bus.aValid = 1'b1;
    bus.aWe    = we;
    bus.aAddr  = addr;
    bus.aWData = wd;
    bus.aMask  = mk;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = bus.aReady;
      @(posedge clk);
      #1;
    end
    bus.aValid = 1'b0;
    if (!acc) checkOutput("acceptTimeout", 0, 1);
  endtask

  // Count cycles after acceptance until the A completion pulse, and A issues seen.
  task automatic waitRsp(output int lat, output int issues, output word_t data, output logic err);
    lat    = 0;
    issues = 0;
    data   = '0;
    err    = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.mEn && !bus.cEn) issues++;
      if (bus.aRspValid) begin
        lat  = k;
        data = bus.aRspData;
        err  = bus.aRspErr;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat == 0) checkOutput("rspTimeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  int    lat;
  int    issues;
  word_t data;
  logic  err;
  int    run;

  initial begin
    rst          = 1'b0;
    bus.cEn      = 1'b0;
    bus.cEnW     = 1'b0;
    bus.cAddr    = '0;
    bus.cReqData = '0;
    bus.cMask    = '0;
    bus.aValid   = 1'b0;
    bus.aWe      = 1'b0;
    bus.aAddr    = '0;
    bus.aWData   = '0;
    bus.aMask    = '0;

    @(negedge clk);
    checkOutput("resetAReady", bus.aReady, 0);
    checkOutput("resetMEn", bus.mEn, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idleAReady", bus.aReady, 1);
    @(posedge clk);
    #1;

    $display("[TB] read with idle port C");
    applyStimulus(1'b0, 30'h100, 32'h0, 4'hF);
    waitRsp(lat, issues, data, err);
    checkOutput("t1Latency", lat, 2);
    checkOutput("t1Issues", issues, 1);
    checkOutput("t1Data", data, 32'h5A5A_0100);
    checkOutput("t1Err", err, 0);

    $display("[TB] write blocked by port C for five cycles");
    bus.cEn      = 1'b1;
    bus.cEnW     = 1'b0;
    bus.cAddr    = 30'h3C;
    bus.cReqData = 32'h1111_2222;
    bus.cMask    = 4'h3;
    applyStimulus(1'b1, 30'h2A0, 32'hCAFE_F00D, 4'hC);
    fork
      begin
        repeat (4) begin
          @(posedge clk);
          #1;
        end
        bus.cEn = 1'b0;
      end
      waitRsp(lat, issues, data, err);
    join
    checkOutput("t2Latency", lat, 6);
    checkOutput("t2Issues", issues, 1);
    checkOutput("t2Data", data, 32'h0);
    checkOutput("t2Err", err, 0);

    $display("[TB] three nAcks then success");
    aNackLimit = aNacksGiven + 3;
    applyStimulus(1'b0, 30'h200, 32'h0, 4'hF);
    waitRsp(lat, issues, data, err);
    checkOutput("t3Latency", lat, 8);
    checkOutput("t3Issues", issues, 4);
    checkOutput("t3Data", data, 32'h5A5A_0200);
    checkOutput("t3Err", err, 0);

    $display("[TB] four nAcks exhaust the replay budget");
    aNackLimit = aNacksGiven + 4;
    applyStimulus(1'b0, 30'h300, 32'h0, 4'hF);
    waitRsp(lat, issues, data, err);
    checkOutput("t4Latency", lat, 8);
    checkOutput("t4Issues", issues, 4);
    checkOutput("t4Err", err, 1);
    checkOutput("t4Data", data, 32'h5A5A_0300);

    $display("[TB] port C load with nAck during A response cycle");
    applyStimulus(1'b0, 30'h40, 32'h0, 4'hF);
    fork
      begin
        @(posedge clk);
        #1;
        bus.cEn   = 1'b1;
        bus.cEnW  = 1'b0;
        bus.cAddr = 30'h77;
        nackC     = 1'b1;
        @(posedge clk);
        #1;
        bus.cEn = 1'b0;
        nackC   = 1'b0;
        @(negedge clk);
        checkOutput("t5CNack", bus.cNack, 1);
        checkOutput("t5CData", bus.cRespData, 32'h5A5A_0077);
        checkOutput("t5ARspQuiet", bus.aRspValid, 0);
      end
      waitRsp(lat, issues, data, err);
    join
    checkOutput("t5Latency", lat, 2);
    checkOutput("t5Data", data, 32'h5A5A_0040);
    checkOutput("t5Err", err, 0);
    @(posedge clk);
    #1;

    $display("[TB] port C stuck on, then reset mid-request");
    bus.cEn   = 1'b1;
    bus.cAddr = 30'h10;
    applyStimulus(1'b1, 30'h500, 32'hABCD_0123, 4'hF);
    run = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.cBackoff && run == 0) run = k;
      @(posedge clk);
      #1;
    end
`ifdef DCACHE_ARB_STARVE_GUARD_EN
    checkOutput("t6BackoffCycle", run, 8);
`else
    checkOutput("t6NoBackoff", run, 0);
`endif
    rst     = 1'b0;
    bus.cEn = 1'b0;
    @(negedge clk);
    checkOutput("t6RstAReady", bus.aReady, 0);
    checkOutput("t6RstBackoff", bus.cBackoff, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("t6NoStaleRsp", bus.aRspValid, 0);
      checkOutput("t6NoStaleIssue", bus.mEn, 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("t6IdleAReady", bus.aReady, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
